lower_mem_responder: RTL and testbench
======================================

Name: lower_mem_responder

Overview:
- Responder end of the L1 miss-repair protocol. Services whole-line refill reads and dirty-line writebacks issued by the L1 cache controller.
- Acts as the lower level (L2/main-memory stand-in) behind the L1 cache controller's READ_LOWER / WRITEBACK sequence.
- Holds lines in an internal word-addressed store with a programmable access latency.
- Transfers each line as a burst of beats under valid/ready handshakes.

Parameters:
- ADDR_W, 32, request address width.
- LINE_BYTES, 128, cache line size (b=7); power of two.
- BEAT_W, 32, data beat width; BEATS = LINE_BYTES*8/BEAT_W (32 by default).
- DEPTH_LINES, 64, lines of backing store; power of two.
- LATENCY, 4, wait cycles between request acceptance and first data beat; 0 is legal.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  L1 presents a line request.
- req_ready  out  1  responder accepts a request (high only in IDLE).
- req_write  in  1  1 = writeback, 0 = refill read.
- req_addr  in  ADDR_W  byte address; low log2(LINE_BYTES) bits ignored.
- wdata_valid  in  1  writeback beat valid.
- wdata_ready  out  1  responder accepts writeback beat.
- wdata  in  BEAT_W  writeback beat data.
- rdata_valid  out  1  refill beat valid.
- rdata_ready  in  1  L1 accepts refill beat.
- rdata  out  BEAT_W  refill beat data.
- rdata_last  out  1  marks the final refill beat.
- wack  out  1  one-cycle pulse: writeback fully committed.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst low, async): state IDLE, counters 0. req_ready=1; wdata_ready, rdata_valid, rdata, rdata_last, wack, busy = 0. Backing store is not cleared.
- Line index = req_addr[log2(LINE_BYTES) +: log2(DEPTH_LINES)]; upper bits alias (wrap modulo DEPTH_LINES).
- States: IDLE, WAIT, READ_BURST, WRITE_BURST, ACK.
- IDLE:
  - Handshake is req_valid && req_ready.
  - On handshake, latch the index and req_write, load the wait counter with LATENCY, and go to WAIT. If LATENCY=0, go directly to the burst state.
- WAIT:
  - Counter decrements each cycle.
  - At 0, go to READ_BURST or WRITE_BURST. The read path prefetches beat 0 so its data is ready on entry.
- Timing: request handshake at cycle T gives first rdata_valid / wdata_ready at cycle T+LATENCY+1.
- READ_BURST:
  - Beats issued in order 0..BEATS-1.
  - rdata_valid stays high until rdata_ready. rdata and rdata_last hold stable while valid && !ready.
  - rdata_last=1 only on beat BEATS-1.
  - Handshake of the last beat returns to IDLE next cycle; rdata_valid drops and req_ready rises then.
  - With rdata_ready tied high, beats stream one per cycle with no bubbles.
- WRITE_BURST:
  - wdata_ready=1 throughout.
  - Each wdata_valid handshake writes wdata to word [index][beat] and increments beat. Cycles without valid are ignored.
  - After beat BEATS-1 handshakes, go to ACK.
- ACK: wack=1 for exactly one cycle, then IDLE.
- Inputs ignored outside their state: req_valid outside IDLE; wdata_valid outside WRITE_BURST; rdata_ready outside READ_BURST.
- Only one transaction is in flight; no request pipelining.
- Read-after-write to the same line returns the written data (write commits before ACK).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. Beats already written stay in the store, so the line may be partially updated.
- Beat counter width is log2(BEATS); it wraps to 0 at the end of each burst.

Test Plan:
- Write then read: LATENCY=4; writeback line 3 with beat i = 0x0300_0000+i, then read line 3 with rdata_ready=1.
  - Request at cycle 0 → rdata_valid cycles 5..36.
  - Data 0x0300_0000..0x0300_001F; rdata_last only at cycle 36; req_ready=1 at cycle 37.
- Read backpressure: toggle rdata_ready every cycle during a read.
  - rdata stable while stalled; each beat delivered exactly once.
  - Burst spans 64 cycles; rdata_last with beat 31 only.
- Write gaps: drive wdata_valid with 1-cycle gaps.
  - Only handshaked beats are stored.
  - wack pulses once, 1 cycle after the 32nd handshake; req_ready 1 cycle after that.
- Aliasing: write line via req_addr 0x0000_0085, then read via 0x0000_2080.
  - Both map to index 1; read returns the written data.
- Reset mid-read: drop rst at beat 10 of a read.
  - rdata_valid=0 and busy=0 asynchronously.
  - After release, a new LATENCY=0 read starts data at T+1.
- Busy hold-off: req_valid held high during an active read.
  - Not accepted until IDLE; accepted on the first cycle req_ready returns to 1.

Source files
------------

// File: rtl/lower_mem_responder.sv
// Lower-level memory responder: services whole-line refill reads and dirty-line writebacks
// as valid/ready beat bursts after a fixed access latency.
module lower_mem_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_BYTES  = 128,
  parameter int unsigned BEAT_W      = 32,
  parameter int unsigned DEPTH_LINES = 64,
  parameter int unsigned LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [BEAT_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [BEAT_W-1:0] rdata,
  output logic              rdata_last,
  output logic              wack,
  output logic              busy
);

  localparam int unsigned Beats = LINE_BYTES * 8 / BEAT_W;
  localparam int unsigned OffW  = $clog2(LINE_BYTES);
  localparam int unsigned IdxW  = $clog2(DEPTH_LINES);
  localparam int unsigned BeatW = $clog2(Beats);
  localparam int unsigned WaitW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned Words = DEPTH_LINES * Beats;

  // WAIT is occupied for LATENCY cycles, so the counter starts one below.
  localparam logic [WaitW-1:0] WaitInit = (LATENCY > 0) ? WaitW'(LATENCY - 1) : '0;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StReadBurst,
    StWriteBurst,
    StAck
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              write_q, write_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [BEAT_W-1:0] rdata_q;

  logic [IdxW-1:0]   req_idx;
  logic [IdxW-1:0]   rd_idx;
  logic [BeatW-1:0]  rd_beat;
  logic              load_rd;
  logic              mem_we;

  logic [BEAT_W-1:0] mem [Words];

  // Upper address bits alias onto the store; line-offset bits are ignored.
  assign req_idx = req_addr[OffW +: IdxW];

  logic unused_addr;
  assign unused_addr = ^{req_addr[ADDR_W-1:OffW+IdxW], req_addr[OffW-1:0]};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    write_d     = write_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    rd_idx      = idx_q;
    rd_beat     = beat_q;
    load_rd     = 1'b0;
    mem_we      = 1'b0;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    wack        = 1'b0;
    busy        = 1'b1;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          idx_d   = req_idx;
          write_d = req_write;
          beat_d  = '0;
          wait_d  = WaitInit;
          if (LATENCY == 0) begin
            if (req_write) begin
              state_d = StWriteBurst;
            end else begin
              state_d = StReadBurst;
              load_rd = 1'b1;
              rd_idx  = req_idx;
              rd_beat = '0;
            end
          end else begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (wait_q == '0) begin
          if (write_q) begin
            state_d = StWriteBurst;
          end else begin
            // Prefetch beat 0 so data is presented on the first burst cycle.
            state_d = StReadBurst;
            load_rd = 1'b1;
            rd_beat = '0;
          end
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end

      StReadBurst: begin
        rdata_valid = 1'b1;
        rdata_last  = (beat_q == LastBeat);
        if (rdata_ready) begin
          beat_d = beat_q + BeatW'(1);
          if (beat_q == LastBeat) begin
            state_d = StIdle;
          end else begin
            load_rd = 1'b1;
            rd_beat = beat_q + BeatW'(1);
          end
        end
      end

      StWriteBurst: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          mem_we = 1'b1;
          beat_d = beat_q + BeatW'(1);
          if (beat_q == LastBeat) begin
            state_d = StAck;
          end
        end
      end

      StAck: begin
        wack    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign rdata = (state_q == StReadBurst) ? rdata_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      write_q <= 1'b0;
      beat_q  <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      if (load_rd) begin
        rdata_q <= mem[{rd_idx, rd_beat}];
      end
    end
  end

  // Backing store keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{idx_q, beat_q}] <= wdata;
    end
  end

endmodule

// File: tb/tb_lower_mem_responder.sv
// Directed bench for lower_mem_responder: scoreboarded refill beats, timing and reset checks
// on a LATENCY=4 instance plus a LATENCY=0 instance.
module tb_lower_mem_responder;

  localparam int unsigned LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [31:0] rdata;
  logic        wack, busy;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr;
  logic        z_wdata_valid, z_wdata_ready;
  logic [31:0] z_wdata;
  logic        z_rdata_valid, z_rdata_ready, z_rdata_last;
  logic [31:0] z_rdata;
  logic        z_wack, z_busy;

  lower_mem_responder #(.LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready), .wdata(wdata), .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .wack(wack), .busy(busy)
  );

  lower_mem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr), .wdata_valid(z_wdata_valid),
    .wdata_ready(z_wdata_ready), .wdata(z_wdata), .rdata_valid(z_rdata_valid),
    .rdata_ready(z_rdata_ready), .rdata(z_rdata), .rdata_last(z_rdata_last),
    .wack(z_wack), .busy(z_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] model [64*32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] addr);
    return int'((addr >> 7) % 64);
  endfunction

  task automatic push_line(input int line);
    for (int b = 0; b < 32; b++) sb.push_back('{data: model[line*32+b], last: (b == 31)});
  endtask

  // Raises req_valid and returns at the sampling point of the handshake cycle.
  task automatic do_req(input logic wr, input logic [31:0] addr, output int t);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    t = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin
        t = cyc;
        break;
      end
    end
    chk("req_accepted", (t >= 0), 1);
  endtask

  task automatic write_line(input logic [31:0] addr, input logic [31:0] base, input bit gaps);
    int line, t, n, first;
    line  = line_of(addr);
    n     = 0;
    first = -1;
    do_req(1'b1, addr, t);
    for (int k = 0; k < 400 && n < 32; k++) begin
      @(posedge clk); #1;
      req_valid   = 1'b0;
      wdata_valid = gaps ? (k % 2 == 0) : 1'b1;
      wdata       = wdata_valid ? base + n : 32'hDEAD_BEEF;
      @(negedge clk);
      if (wdata_ready && first < 0) first = cyc;
      if (wdata_valid && wdata_ready) begin
        model[line*32+n] = base + n;
        n++;
      end
    end
    chk("wr_first_ready", first - t, LATENCY + 1);
    chk("wr_beats", n, 32);
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    @(negedge clk);
    chk("wr_wack_pulse", wack, 1);
    chk("wr_busy_in_ack", busy, 1);
    chk("wr_ready_in_ack", req_ready, 0);
    @(negedge clk);
    chk("wr_wack_done", wack, 0);
    chk("wr_idle_ready", req_ready, 1);
  endtask

  task automatic read_line(input logic [31:0] addr, input bit toggle);
    int t, first, fin;
    bit done;
    first = -1;
    fin   = -1;
    done  = 1'b0;
    push_line(line_of(addr));
    do_req(1'b0, addr, t);
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); #1;
      req_valid   = 1'b0;
      rdata_ready = toggle ? ((cyc - t) % 2 == 0) : 1'b1;
      @(negedge clk);
      if (rdata_valid && first < 0) first = cyc;
      if (rdata_valid && rdata_ready && rdata_last) begin
        done = 1'b1;
        fin  = cyc;
      end
    end
    chk("rd_first_valid", first - t, LATENCY + 1);
    chk("rd_last_cycle", fin - t, LATENCY + (toggle ? 64 : 32));
    @(negedge clk);
    chk("rd_idle_ready", req_ready, 1);
    chk("rd_idle_valid", rdata_valid, 0);
    chk("rd_all_beats", sb.size(), 0);
  endtask

  // Scoreboard monitor: each refill handshake pops one expected beat.
  logic        stalled = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;
  always @(negedge clk) begin
    if (rst && rdata_valid) begin
      if (stalled) begin
        chk("rd_stall_data", rdata, prev_d);
        chk("rd_stall_last", rdata_last, prev_l);
      end
      if (rdata_ready) begin
        chk("rd_beat_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          chk("rd_data", rdata, sb[0].data);
          chk("rd_last", rdata_last, sb[0].last);
          void'(sb.pop_front());
        end
      end
      stalled <= !rdata_ready;
      prev_d  <= rdata;
      prev_l  <= rdata_last;
    end else begin
      stalled <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, fin, n;
    bit done, seen;
    logic [31:0] zbase;

    rst = 1'b0;
    {req_valid, req_write, wdata_valid, rdata_ready} = '0;
    req_addr = '0;
    wdata    = '0;
    {z_req_valid, z_req_write, z_wdata_valid, z_rdata_ready} = '0;
    z_req_addr = '0;
    z_wdata    = '0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rdata_last", rdata_last, 0);
    chk("rst_wack", wack, 0);
    chk("rst_busy", busy, 0);
    #20;
    @(posedge clk); #1;
    rst = 1'b1;
    rdata_ready = 1'b1;

    // Write then read line 3.
    write_line(32'h0000_0180, 32'h0300_0000, 1'b0);
    read_line(32'h0000_0180, 1'b0);

    // Gapped writeback, then backpressured refill.
    write_line(32'h0000_0280, 32'h0500_0000, 1'b1);
    read_line(32'h0000_0280, 1'b1);

    // 0x85 and 0x2080 both land on line 1.
    write_line(32'h0000_0085, 32'h0100_0000, 1'b0);
    read_line(32'h0000_2080, 1'b0);

    // Busy hold-off: a second read held on req_valid during an active one.
    rdata_ready = 1'b1;
    push_line(3);
    do_req(1'b0, 32'h0000_0180, t);
    seen = 1'b0;
    done = 1'b0;
    fin  = -1;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); #1;
      req_addr = 32'h0000_0080;
      @(negedge clk);
      if (req_ready) seen = 1'b1;
      if (rdata_valid && rdata_ready && rdata_last) begin
        done = 1'b1;
        fin  = cyc;
      end
    end
    chk("hold_not_accepted", seen, 0);
    chk("hold_first_done", fin - t, LATENCY + 32);
    push_line(1);
    @(negedge clk);
    chk("hold_ready_back", req_ready, 1);
    t2 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold_accepted_busy", busy, 1);
    chk("hold_accepted_wait", rdata_valid, 0);
    done = 1'b0;
    fin  = -1;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (rdata_valid && rdata_ready && rdata_last) begin
        done = 1'b1;
        fin  = cyc;
      end
    end
    chk("hold_second_done", fin - t2, LATENCY + 32);
    @(negedge clk);
    chk("hold_all_beats", sb.size(), 0);

    // LATENCY=0 instance: write line 2, read and reset mid-burst, then read again.
    zbase = 32'h0A00_0000;
    @(posedge clk); #1;
    z_req_valid   = 1'b1;
    z_req_write   = 1'b1;
    z_req_addr    = 32'h0000_0100;
    z_wdata_valid = 1'b1;
    z_wdata       = zbase;
    n = 0;
    for (int k = 0; k < 200 && n < 32; k++) begin
      @(negedge clk);
      if (z_wdata_valid && z_wdata_ready) n++;
      @(posedge clk); #1;
      z_req_valid = 1'b0;
      z_wdata     = zbase + n;
    end
    z_wdata_valid = 1'b0;
    @(negedge clk);
    chk("z_wack", z_wack, 1);

    @(posedge clk); #1;
    z_req_valid   = 1'b1;
    z_req_write   = 1'b0;
    z_rdata_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge clk);
      if (z_rdata_valid && z_rdata_ready) begin
        chk("z_pre_rst_data", z_rdata, zbase + n);
        n++;
      end
      @(posedge clk); #1;
      z_req_valid = 1'b0;
    end
    chk("z_beat10_data", z_rdata, zbase + 10);
    #1;
    rst = 1'b0;
    #1;
    chk("z_rst_rdata_valid", z_rdata_valid, 0);
    chk("z_rst_busy", z_busy, 0);
    chk("z_rst_req_ready", z_req_ready, 1);
    chk("z_rst_rdata_last", z_rdata_last, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    @(posedge clk); #1;
    z_req_valid = 1'b1;
    @(negedge clk);
    chk("z_req_ready", z_req_ready, 1);
    t = cyc;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_first_valid", z_rdata_valid, 1);
    n    = 0;
    done = 1'b0;
    fin  = -1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (z_rdata_valid) begin
        chk("z_data", z_rdata, zbase + n);
        chk("z_last", z_rdata_last, (n == 31));
        if (n == 31) begin
          done = 1'b1;
          fin  = cyc;
        end
        n++;
      end
      if (!done) @(negedge clk);
    end
    chk("z_last_cycle", fin - t, 32);
    @(negedge clk);
    chk("z_idle_ready", z_req_ready, 1);
    chk("z_idle_valid", z_rdata_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
